i2c_codec_responder: RTL and testbench

I2C responder (slave) that emulates the WM8731 codec control port. It is the other end of the design's 100 kHz I2C codec-initialization initiator. It oversamples SCL/SDA on the system clock, ACKs 3-byte codec writes addressed to DEV_ADDR, and presents each decoded register write as a one-cycle strobe. It serves as the board-level loopback target and the simulation model that checks the init sequence.

---
 rtl/i2c_resp_pkg.sv | 65 ++++++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_codec_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the WM8731-style I2C codec responder.
package i2c_resp_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned REG_AW       = 7;
  localparam int unsigned REG_DW       = 9;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned SHADOW_AW    = 4;
  localparam int unsigned SHADOW_DEPTH = 16;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // WM8731 register indices
  localparam logic [SHADOW_AW-1:0] REG_LLINE_IN   = 4'd0;
  localparam logic [SHADOW_AW-1:0] REG_RLINE_IN   = 4'd1;
  localparam logic [SHADOW_AW-1:0] REG_LHP_OUT    = 4'd2;
  localparam logic [SHADOW_AW-1:0] REG_RHP_OUT    = 4'd3;
  localparam logic [SHADOW_AW-1:0] REG_APATH      = 4'd4;
  localparam logic [SHADOW_AW-1:0] REG_DPATH      = 4'd5;
  localparam logic [SHADOW_AW-1:0] REG_POWER      = 4'd6;
  localparam logic [SHADOW_AW-1:0] REG_IFACE      = 4'd7;
  localparam logic [SHADOW_AW-1:0] REG_SRATE      = 4'd8;
  localparam logic [SHADOW_AW-1:0] REG_ACTIVE     = 4'd9;
  localparam logic [SHADOW_AW-1:0] REG_LAST_DEF   = 4'd10;
  localparam logic [SHADOW_AW-1:0] REG_RESET      = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_IGNORE
  } state_e;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } reg_wr_t;

  // Power-on defaults for registers 0..10
  function automatic logic [REG_DW-1:0] wm8731_default(input logic [SHADOW_AW-1:0] idx);
    logic [REG_DW-1:0] val;
    val = '0;
    case (idx)
      REG_LLINE_IN: val = 9'h097;
      REG_RLINE_IN: val = 9'h097;
      REG_LHP_OUT:  val = 9'h079;
      REG_RHP_OUT:  val = 9'h079;
      REG_APATH:    val = 9'h00A;
      REG_DPATH:    val = 9'h008;
      REG_POWER:    val = 9'h09F;
      REG_IFACE:    val = 9'h00A;
      REG_SRATE:    val = 9'h000;
      REG_ACTIVE:   val = 9'h000;
      default:      val = 9'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus one history stage; derives SCL edges and START/STOP.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus is high, so the chains come out of reset at 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // START/STOP need SCL steady high across both samples, so a coincident SCL edge reads as data
  assign o_sda        = sda_s;
  assign o_scl_rise_c = scl_s & ~scl_hist_q;
  assign o_scl_fall_c = ~scl_s & scl_hist_q;
  assign o_start_c    = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign o_stop_c     = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// WM8731 control-port emulator: ACKs 3-byte writes and strobes each decoded register write.
// Define I2C_RESP_SHADOW_EN to add a 16x9 shadow register file with an async read port.
module i2c_codec_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_scl,
  input  logic                i_sda,
  output logic                o_sda_oe,
  output logic                o_reg_wr_valid,
  output logic [REG_AW-1:0]   o_reg_addr,
  output logic [REG_DW-1:0]   o_reg_data,
  output logic [CNT_W-1:0]    o_wr_count,
  output logic                o_busy,
  output logic                o_err
`ifdef I2C_RESP_SHADOW_EN
  ,
  input  logic [SHADOW_AW-1:0] i_rd_addr,
  output logic [REG_DW-1:0]    o_rd_data
`endif
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_scl        (i_scl),
    .i_sda        (i_sda),
    .o_sda        (sda_s),
    .o_scl_rise_c (scl_rise),
    .o_scl_fall_c (scl_fall),
    .o_start_c    (start_det),
    .o_stop_c     (stop_det)
  );

  state_e                 state_q,    state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [BYTE_W-1:0]      shift_q,    shift_d;
  logic [BYTE_W-1:0]      byte1_q,    byte1_d;
  logic                   sda_oe_q,   sda_oe_d;
  logic                   matched_q,  matched_d;
  logic                   busy_q,     busy_d;
  logic                   err_q,      err_d;
  reg_wr_t                wr_q,       wr_d;
  logic [CNT_W-1:0]       wr_cnt_q,   wr_cnt_d;
  logic                   wr_pend_q,  wr_pend_d;
  logic                   wr_valid_q;

  logic [BYTE_W-1:0]      byte_in;
  logic                   last_bit;

  assign byte_in  = {shift_q[BYTE_W-2:0], sda_s};
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));

  // Next-state: STOP and START override whatever the byte engine is doing
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte1_d   = byte1_q;
    sda_oe_d  = sda_oe_q;
    matched_d = matched_q;
    busy_d    = busy_q;
    err_d     = err_q;
    wr_d      = wr_q;
    wr_cnt_d  = wr_cnt_q;
    wr_pend_d = 1'b0;

    if (stop_det) begin
      if (matched_q && (state_q != ST_IGNORE) && (state_q != ST_IDLE)) begin
        err_d = 1'b1;
      end
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      matched_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      matched_d = 1'b0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit) begin
              if (byte_in[7:1] == DEV_ADDR && byte_in[0] == RW_WRITE) begin
                matched_d = 1'b1;
                state_d   = ST_ACK_A;
              end else begin
                // Reads are unsupported: flag only when they target this device
                if (byte_in[7:1] == DEV_ADDR) err_d = 1'b1;
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_BYTE1: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit) begin
              byte1_d = byte_in;
              state_d = ST_ACK_1;
            end
          end
        end
        ST_BYTE2: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit) state_d = ST_ACK_2;
          end
        end
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          // First falling edge starts the ACK slot, the second one ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ST_ACK_A) begin
                state_d = ST_BYTE1;
              end else if (state_q == ST_ACK_1) begin
                state_d = ST_BYTE2;
              end else begin
                wr_d.addr = byte1_q[7:1];
                wr_d.data = {byte1_q[0], shift_q};
                wr_cnt_d  = wr_cnt_q + CNT_W'(1);
                wr_pend_d = 1'b1;
                state_d   = ST_IGNORE;
              end
            end
          end
        end
        ST_IGNORE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (last_bit && matched_q) err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      sda_oe_q   <= 1'b0;
      matched_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= '0;
      wr_cnt_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      sda_oe_q   <= sda_oe_d;
      matched_q  <= matched_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_valid_q <= wr_pend_q;
    end
  end

  assign o_sda_oe       = sda_oe_q;
  assign o_reg_wr_valid = wr_valid_q;
  assign o_reg_addr     = wr_q.addr;
  assign o_reg_data     = wr_q.data;
  assign o_wr_count     = wr_cnt_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;

`ifdef I2C_RESP_SHADOW_EN
  logic [REG_DW-1:0] shadow_q [SHADOW_DEPTH];

  // Shadow updates ride on the strobe cycle, when wr_q already holds the new write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
        shadow_q[SHADOW_AW'(i)] <= '0;
      end
    end else if (wr_pend_q) begin
      if (wr_q.addr <= REG_AW'(REG_LAST_DEF)) begin
        shadow_q[wr_q.addr[SHADOW_AW-1:0]] <= wr_q.data;
      end else if (wr_q.addr == REG_AW'(REG_RESET)) begin
        for (int unsigned i = 0; i <= 10; i++) begin
          shadow_q[SHADOW_AW'(i)] <= wm8731_default(SHADOW_AW'(i));
        end
      end
    end
  end

  assign o_rd_data = shadow_q[i_rd_addr];
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench: bit-banged 100 kHz I2C master against the codec responder.
module tb_i2c_codec_responder;

  localparam int HALF = 40;
  localparam int Q    = 2500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;

  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [7:0] wr_count;
  logic       busy;
  logic       err;
`ifdef I2C_RESP_SHADOW_EN
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         s_cyc = 0;
  int         fall_cyc = 0;
  logic [6:0] s_addr = '0;
  logic [8:0] s_data = '0;
  logic       oe_seen = 1'b0;
  logic       ack;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_codec_responder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_scl          (scl),
    .i_sda          (sda_line),
    .o_sda_oe       (sda_oe),
    .o_reg_wr_valid (wr_valid),
    .o_reg_addr     (reg_addr),
    .o_reg_data     (reg_data),
    .o_wr_count     (wr_count),
    .o_busy         (busy),
    .o_err          (err)
`ifdef I2C_RESP_SHADOW_EN
    ,
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data)
`endif
  );

  always #HALF clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (wr_valid) begin
      strobes = strobes + 1;
      s_addr  = reg_addr;
      s_data  = reg_data;
      s_cyc   = cyc;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b0; #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b);
    sda_drv = b; #Q;
    scl = 1'b1;  #(2*Q);
    scl = 1'b0;  #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) i2c_bit(b[7-i]);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    a = ~sda_line;  #Q;
    scl = 1'b0;
    fall_cyc = cyc; #Q;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_oe"},    32'(sda_oe),   32'h0);
    chk({tag, "_valid"}, 32'(wr_valid), 32'h0);
    chk({tag, "_addr"},  32'(reg_addr), 32'h0);
    chk({tag, "_data"},  32'(reg_data), 32'h0);
    chk({tag, "_count"}, 32'(wr_count), 32'h0);
    chk({tag, "_busy"},  32'(busy),     32'h0);
    chk({tag, "_err"},   32'(err),      32'h0);
  endtask

  initial begin
    // Odd offset keeps every bus transition away from clock edges
    #1007;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #Q;

    // Plain write: reg 4 <= 0x015
    i2c_start();
    chk("t1_busy", 32'(busy), 32'h1);
    i2c_byte(8'h34, ack); chk("t1_ack_a", 32'(ack), 32'h1);
    i2c_byte(8'h08, ack); chk("t1_ack_1", 32'(ack), 32'h1);
    i2c_byte(8'h15, ack); chk("t1_ack_2", 32'(ack), 32'h1);
    chk("t1_latency", 32'(s_cyc - fall_cyc), 32'd4);
    i2c_stop();
    #Q;
    chk("t1_strobes", 32'(strobes), 32'd1);
    chk("t1_s_addr", 32'(s_addr), 32'h04);
    chk("t1_s_data", 32'(s_data), 32'h015);
    chk("t1_held_addr", 32'(reg_addr), 32'h04);
    chk("t1_count", 32'(wr_count), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_err", 32'(err), 32'h0);

    // Wrong device address
    strobes = 0; oe_seen = 1'b0;
    i2c_start();
    i2c_byte(8'h36, ack); chk("t2_ack_a", 32'(ack), 32'h0);
    i2c_byte(8'h08, ack);
    i2c_byte(8'h15, ack);
    i2c_stop();
    #Q;
    chk("t2_oe_seen", 32'(oe_seen), 32'h0);
    chk("t2_strobes", 32'(strobes), 32'd0);
    chk("t2_err", 32'(err), 32'h0);
    chk("t2_count", 32'(wr_count), 32'd1);

    // Read request to our address
    i2c_start();
    i2c_byte(8'h35, ack); chk("t3_ack_a", 32'(ack), 32'h0);
    i2c_stop();
    #Q;
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_strobes", 32'(strobes), 32'd0);
    chk("t3_oe_seen", 32'(oe_seen), 32'h0);

    rst_n = 1'b0; #Q;
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_count", 32'(wr_count), 32'd0);
    rst_n = 1'b1; #Q;

    // STOP before the data byte
    i2c_start();
    i2c_byte(8'h34, ack); chk("t4_ack_a", 32'(ack), 32'h1);
    i2c_byte(8'h0F, ack); chk("t4_ack_1", 32'(ack), 32'h1);
    i2c_stop();
    #Q;
    chk("t4_strobes", 32'(strobes), 32'd0);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_count", 32'(wr_count), 32'd0);

    // Repeated START mid-byte1, then RESET register write
    i2c_start();
    i2c_byte(8'h34, ack);
    send_bits(8'h0E, 3);
    i2c_start();
    chk("t5_busy", 32'(busy), 32'h1);
    i2c_byte(8'h34, ack); chk("t5_ack_a", 32'(ack), 32'h1);
    i2c_byte(8'h1E, ack); chk("t5_ack_1", 32'(ack), 32'h1);
    i2c_byte(8'h00, ack); chk("t5_ack_2", 32'(ack), 32'h1);
    i2c_stop();
    #Q;
    chk("t5_strobes", 32'(strobes), 32'd1);
    chk("t5_s_addr", 32'(s_addr), 32'h0F);
    chk("t5_s_data", 32'(s_data), 32'h000);
    chk("t5_count", 32'(wr_count), 32'd1);
`ifdef I2C_RESP_SHADOW_EN
    rd_addr = 4'd4; #Q;
    chk("t5_shadow4", 32'(rd_data), 32'h00A);
    rd_addr = 4'd0; #Q;
    chk("t5_shadow0", 32'(rd_data), 32'h097);
`endif

    // Reset during BYTE1, then a clean write to reg 7 and an extra byte
    strobes = 0;
    i2c_start();
    i2c_byte(8'h34, ack);
    send_bits(8'h0E, 3);
    rst_n = 1'b0; #Q;
    chk_all_zero("t6_rst");
    rst_n = 1'b1;
    send_bits(8'hFF, 5);
    #Q;
    chk("t6_idle_busy", 32'(busy), 32'h0);
    i2c_start();
    i2c_byte(8'h34, ack); chk("t6_ack_a", 32'(ack), 32'h1);
    i2c_byte(8'h0E, ack); chk("t6_ack_1", 32'(ack), 32'h1);
    i2c_byte(8'h42, ack); chk("t6_ack_2", 32'(ack), 32'h1);
    #Q;
    chk("t6_strobes", 32'(strobes), 32'd1);
    chk("t6_s_addr", 32'(s_addr), 32'h07);
    chk("t6_s_data", 32'(s_data), 32'h042);
    chk("t6_count", 32'(wr_count), 32'd1);
    chk("t6_err_pre", 32'(err), 32'h0);
    i2c_byte(8'h55, ack); chk("t6_ack_4th", 32'(ack), 32'h0);
    chk("t6_err_4th", 32'(err), 32'h1);
    i2c_stop();
    #Q;
    chk("t6_busy_end", 32'(busy), 32'h0);
    chk("t6_strobes_end", 32'(strobes), 32'd1);
`ifdef I2C_RESP_SHADOW_EN
    rd_addr = 4'd7; #Q;
    chk("t6_shadow7", 32'(rd_data), 32'h042);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
